// File: rtl/equal_check_pkg.sv
// Shared types and LFSR helper for the equality-comparator cross-check sequencer.
// Holds the FSM state enum, the Galois feedback mask and the LFSR step function.
package equal_check_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    // x^32 + x^22 + x^2 + x + 1, right-shifting Galois form
    localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

    function automatic logic [31:0] lfsr_next(input logic [31:0] v);
        return (v >> 1) ^ (v[0] ? LFSR_MASK : 32'h0);
    endfunction

endpackage

// File: rtl/equal_check_lfsr.sv
// 32-bit Galois LFSR operand source with synchronous reload.
// Ports: clk, rst (sync, active-high), load (reload SEED), step (advance once), value (state).
module equal_check_lfsr
    import equal_check_pkg::*;
#(
    parameter logic [31:0] SEED = 32'hACE1_2011
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        step,
    output logic [31:0] value
);

    always_ff @(posedge clk) begin
        if (rst || load) begin
            value <= SEED;
        end else if (step) begin
            value <= lfsr_next(value);
        end
    end

endmodule

// File: rtl/equal_check_seq.sv
// Cross-check sequencer: drives LFSR operands to a reference and a DUT comparator,
// samples both after a settle delay and checks them against a golden a==b.
// Ports: clk, rst, start, abort in; a, b operands out; res_ref, res_dut in;
// busy, done, pass, err_pulse status; err_cnt, vec_cnt, first_a, first_b results.
module equal_check_seq
    import equal_check_pkg::*;
#(
    parameter int          WIDTH     = 16,
    parameter int          N_VECTORS = 20000,
    parameter int          SETTLE    = 2,
    parameter logic [31:0] SEED      = 32'hACE1_2011,
    parameter int          ERR_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    input  logic             res_ref,
    input  logic             res_dut,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_cnt,
    output logic [31:0]      vec_cnt,
    output logic [WIDTH-1:0] first_a,
    output logic [WIDTH-1:0] first_b
);

    localparam logic [3:0]  SETTLE_INIT = 4'(SETTLE > 0 ? SETTLE - 1 : 0);
    localparam logic [31:0] N_LAST      = 32'(N_VECTORS);

    state_t      state;
    state_t      state_next;
    logic [3:0]  settle_cnt;
    logic [31:0] lfsr;
    logic [31:0] vec_next;
    logic        go;
    logic        exp_eq;
    logic        mismatch;

    // A run is (re)started only from IDLE/DONE, and abort always wins over start
    assign go       = (state == S_IDLE || state == S_DONE) && start && !abort;
    assign vec_next = vec_cnt + 32'd1;
    assign exp_eq   = (a == b);
    assign mismatch = (res_ref != exp_eq) || (res_dut != exp_eq);

    equal_check_lfsr #(
        .SEED(SEED)
    ) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .load (go),
        .step (state == S_APPLY),
        .value(lfsr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE: begin
                if (start && !abort) state_next = S_APPLY;
            end
            S_APPLY: begin
                if (abort)           state_next = S_IDLE;
                else if (SETTLE > 0) state_next = S_SETTLE;
                else                 state_next = S_SAMPLE;
            end
            S_SETTLE: begin
                if (abort)                state_next = S_IDLE;
                else if (settle_cnt == 0) state_next = S_SAMPLE;
            end
            S_SAMPLE: begin
                if (abort)                 state_next = S_IDLE;
                else if (vec_next == N_LAST) state_next = S_DONE;
                else                       state_next = S_APPLY;
            end
            S_DONE: begin
                if (start) state_next = abort ? S_IDLE : S_APPLY;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state == S_APPLY) || (state == S_SETTLE) || (state == S_SAMPLE);
        done      = (state == S_DONE);
        pass      = done && (err_cnt == '0);
        err_pulse = (state == S_SAMPLE) && mismatch;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a          <= '0;
            b          <= '0;
            settle_cnt <= '0;
            err_cnt    <= '0;
            vec_cnt    <= '0;
            first_a    <= '0;
            first_b    <= '0;
        end else if (go) begin
            err_cnt <= '0;
            vec_cnt <= '0;
            first_a <= '0;
            first_b <= '0;
        end else begin
            unique case (state)
                S_APPLY: begin
                    // every 4th vector is forced equal to exercise the a==b path
                    a          <= lfsr[WIDTH-1:0];
                    b          <= (vec_cnt[1:0] == 2'd0) ? lfsr[WIDTH-1:0]
                                                         : lfsr[WIDTH+15:16];
                    settle_cnt <= SETTLE_INIT;
                end
                S_SETTLE: begin
                    if (settle_cnt != 0) settle_cnt <= settle_cnt - 4'd1;
                end
                S_SAMPLE: begin
                    vec_cnt <= vec_next;
                    if (mismatch) begin
                        if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
                        if (err_cnt == '0) begin
                            first_a <= a;
                            first_b <= b;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_equal_check_seq.sv
// Randomized-order self-checking bench for equal_check_seq with a vector-level model.
// Two instances run in lockstep: full-width error counter and a 2-bit saturating one.
module tb_equal_check_seq;

    localparam int          W    = 16;
    localparam int          N    = 8;
    localparam int          ST   = 1;
    localparam int          PER  = 2 + ST;
    localparam logic [31:0] SEED = 32'hACE1_2011;
    localparam logic [31:0] MASK = 32'h8020_0003;

    logic clk = 1'b0;
    logic rst, start, abort;
    logic [W-1:0] a, b, a2, b2, first_a, first_b, first_a2, first_b2;
    logic res_ref, res_dut, res_ref2, res_dut2;
    logic busy, done, pass, err_pulse, busy2, done2, pass2, err_pulse2;
    logic [15:0] err_cnt;
    logic [1:0]  err_cnt2;
    logic [31:0] vec_cnt, vec_cnt2;

    int mode;
    int errors = 0;
    int checks = 0;

    logic [W-1:0] va [N];
    logic [W-1:0] vb [N];
    bit           mis [N];
    int           ecnt [N+1];
    int           first_idx;

    bit run_on = 1'b0;
    bit frozen = 1'b1;
    int s = 0;

    always #5 clk = ~clk;

    equal_check_seq #(.WIDTH(W), .N_VECTORS(N), .SETTLE(ST), .SEED(SEED), .ERR_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .a(a), .b(b),
        .res_ref(res_ref), .res_dut(res_dut), .busy(busy), .done(done), .pass(pass),
        .err_pulse(err_pulse), .err_cnt(err_cnt), .vec_cnt(vec_cnt),
        .first_a(first_a), .first_b(first_b)
    );

    equal_check_seq #(.WIDTH(W), .N_VECTORS(N), .SETTLE(ST), .SEED(SEED), .ERR_W(2)) dut_sat (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .a(a2), .b(b2),
        .res_ref(res_ref2), .res_dut(res_dut2), .busy(busy2), .done(done2), .pass(pass2),
        .err_pulse(err_pulse2), .err_cnt(err_cnt2), .vec_cnt(vec_cnt2),
        .first_a(first_a2), .first_b(first_b2)
    );

    // comparator models: 0 ideal, 1 inverted, 2 stuck-at-0
    always_comb begin
        res_ref  = (a == b);
        res_dut  = (mode == 0) ? (a == b) : (mode == 1) ? (a != b) : 1'b0;
        res_ref2 = (a2 == b2);
        res_dut2 = (mode == 0) ? (a2 == b2) : (mode == 1) ? (a2 != b2) : 1'b0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic void build(input int m);
        logic [31:0] l;
        l = SEED;
        first_idx = -1;
        ecnt[0] = 0;
        for (int i = 0; i < N; i++) begin
            va[i] = l[15:0];
            vb[i] = (i % 4 == 0) ? l[15:0] : l[31:16];
            mis[i] = (m == 1) ? 1'b1 : (m == 2) ? (va[i] == vb[i]) : 1'b0;
            if (mis[i] && first_idx < 0) first_idx = i;
            ecnt[i+1] = ecnt[i] + int'(mis[i]);
            l = l[0] ? ((l >> 1) ^ MASK) : (l >> 1);
        end
    endfunction

    // cycles since the edge that accepted start
    always @(posedge clk) begin
        if (rst)        run_on <= 1'b0;
        else if (abort) run_on <= 1'b0;
        else if (start) begin
            run_on <= 1'b1;
            s <= 0;
        end else if (run_on) s <= s + 1;
    end

    always @(negedge clk) begin : cmp
        int i, p, k, e, es;
        logic exp_pass;
        if (run_on && !frozen) begin
            if (s < N * PER) begin
                i = s / PER;
                p = s % PER;
                k = i;
                exp_pass = 1'b0;
                chk("busy", busy, 1);
                chk("done", done, 0);
                chk("err_pulse", err_pulse, (p == PER - 1) && mis[i]);
                if (p != 0) begin
                    chk("a", a, va[i]);
                    chk("b", b, vb[i]);
                end else if (i > 0) begin
                    chk("a_hold", a, va[i-1]);
                    chk("b_hold", b, vb[i-1]);
                end
            end else begin
                k = N;
                exp_pass = (ecnt[N] == 0);
                chk("busy_done", busy, 0);
                chk("done_done", done, 1);
                chk("err_pulse_done", err_pulse, 0);
                chk("a_done", a, va[N-1]);
                chk("b_done", b, vb[N-1]);
            end
            e  = ecnt[k];
            es = (e > 3) ? 3 : e;
            chk("pass", pass, exp_pass);
            chk("pass_sat", pass2, exp_pass);
            chk("vec_cnt", vec_cnt, k);
            chk("vec_cnt_sat", vec_cnt2, k);
            chk("err_cnt", err_cnt, e);
            chk("err_cnt_sat", err_cnt2, es);
            chk("first_a", first_a, (e > 0) ? va[first_idx] : 16'h0);
            chk("first_b", first_b, (e > 0) ? vb[first_idx] : 16'h0);
        end
    end

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic begin_run(input int m);
        frozen = 1'b1;
        mode = m;
        build(m);
        pulse_start();
        frozen = 1'b0;
    endtask

    task automatic wait_done(output int busy_n, output int pulse_n);
        busy_n = 0;
        pulse_n = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (done) break;
            if (busy) busy_n++;
            if (err_pulse) pulse_n++;
        end
        chk("done_reached", done, 1);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_a"}, a, 0);
        chk({tag, "_b"}, b, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_pass"}, pass, 0);
        chk({tag, "_err_pulse"}, err_pulse, 0);
        chk({tag, "_err_cnt"}, err_cnt, 0);
        chk({tag, "_vec_cnt"}, vec_cnt, 0);
        chk({tag, "_first_a"}, first_a, 0);
        chk({tag, "_first_b"}, first_b, 0);
        chk({tag, "_err_cnt_sat"}, err_cnt2, 0);
    endtask

    initial begin : main
        int bn, pn, order, idle_gap;
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        mode = 0;
        build(0);

        chk("model_v0a", va[0], 16'h2011);
        chk("model_v1a", va[1], 16'h900B);
        chk("model_v1b", vb[1], 16'hD650);
        chk("model_v7b", vb[7], 16'hD76C);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("rst");
        @(posedge clk);
        #1 rst = 1'b0;
        idle_gap = int'($urandom_range(0, 3));
        repeat (idle_gap) @(posedge clk);

        begin_run(0);
        wait_done(bn, pn);
        chk("clean_busy_cycles", bn, 24);
        chk("clean_pulses", pn, 0);
        chk("clean_pass", pass, 1);
        chk("clean_err_cnt", err_cnt, 0);
        chk("clean_vec_cnt", vec_cnt, 8);
        chk("clean_a_last", a, 16'h4242);

        // inverted and stuck runs in random order
        order = int'($urandom_range(0, 1));
        for (int r = 0; r < 2; r++) begin
            idle_gap = int'($urandom_range(0, 3));
            repeat (idle_gap) @(posedge clk);
            if ((r ^ order) == 0) begin
                begin_run(1);
                wait_done(bn, pn);
                chk("inv_err_cnt", err_cnt, 8);
                chk("inv_pass", pass, 0);
                chk("inv_pulses", pn, 8);
                chk("inv_first_a", first_a, 16'h2011);
                chk("inv_first_b", first_b, 16'h2011);
                chk("inv_sat", err_cnt2, 3);
            end else begin
                begin_run(2);
                wait_done(bn, pn);
                chk("stuck_err_cnt", err_cnt, 2);
                chk("stuck_pulses", pn, 2);
                chk("stuck_pass", pass, 0);
                chk("stuck_sat", err_cnt2, 2);
            end
        end

        // abort once vec_cnt reaches 3
        begin_run(0);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (vec_cnt == 3) break;
        end
        chk("abort_reach", vec_cnt, 3);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_pass", pass, 0);
        chk("abort_vec_cnt", vec_cnt, 3);
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        chk("start_abort_busy", busy, 0);
        chk("start_abort_vec_cnt", vec_cnt, 3);

        begin_run(0);
        wait_done(bn, pn);
        chk("restart_busy_cycles", bn, 24);
        chk("restart_pass", pass, 1);

        // reset in the middle of SETTLE
        begin_run(0);
        @(negedge clk);
        @(negedge clk);
        chk("mid_settle_busy", busy, 1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_vals("midrst");

        begin_run(0);
        wait_done(bn, pn);
        chk("post_rst_busy_cycles", bn, 24);
        chk("post_rst_pass", pass, 1);
        chk("post_rst_vec_cnt", vec_cnt, 8);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
